// File: rtl/huffman_pkg.sv
// Shared definitions for the bit-serial Huffman link (encoder and decoder).
// Codes are stored left-aligned: the first transmitted bit sits in code[8].
package huffman_pkg;

  localparam int SYM_W        = 5;
  localparam int MAX_CODE_LEN = 9;
  localparam int NUM_SYMS     = 18;

  typedef struct packed {
    logic [3:0] len;
    logic [8:0] code;
  } huff_code_t;

  // Canonical code table; len == 0 marks an illegal symbol (0, 19..31).
  function automatic huff_code_t huff_lookup(input logic [SYM_W-1:0] sym);
    huff_code_t c;
    c.len  = 4'd0;
    c.code = 9'd0;
    case (sym)
      5'd1: begin c.len = 4'd1; c.code = 9'b0_00000000; end
      5'd2: begin c.len = 4'd2; c.code = 9'b10_0000000; end
      5'd3: begin c.len = 4'd4; c.code = 9'b1100_00000; end
      5'd4: begin c.len = 4'd4; c.code = 9'b1101_00000; end
      5'd5: begin c.len = 4'd4; c.code = 9'b1110_00000; end
      5'd6: begin c.len = 4'd6; c.code = 9'b111100_000; end
      5'd7: begin c.len = 4'd6; c.code = 9'b111101_000; end
      5'd8: begin c.len = 4'd7; c.code = 9'b1111100_00; end
      default: begin
        // Symbols 9..18 take consecutive 9-bit codes starting at 111110100.
        if (sym >= 5'd9 && sym <= 5'd18) begin
          c.len  = 4'd9;
          c.code = 9'b111110100 + {4'd0, sym - 5'd9};
        end
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// Purely combinational symbol-to-code table for the Huffman encoder.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output huff_code_t       code_o
);

  // Table lookup; illegal symbols come back with len == 0.
  always_comb begin
    code_o = huff_lookup(sym_i);
  end

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: accepts symbols 1..18 over valid/ready and shifts
// the canonical code out MSB-first, one bit per clock, with no gap between
// back-to-back codes.
// Optional feature: define HUFF_ENC_ERR_CHECK_EN to get a registered one-cycle
// err_out pulse after each illegal symbol; otherwise err_out is tied low.
module huffman_encoder
  import huffman_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_first,
  output logic             busy,
  output logic             err_out,
  output logic [CNT_W-1:0] sym_count
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [8:0]       sreg_q, sreg_d;
  logic [3:0]       cnt_q, cnt_d;      // bits left, including the one on bit_out
  logic             first_q, first_d;
  logic [CNT_W-1:0] sym_count_q, sym_count_d;

  huff_code_t rom_code;
  logic       accept;
  logic       legal;
  logic       last_bit;

  huffman_code_rom u_rom (
    .sym_i  (sym_in),
    .code_o (rom_code)
  );

  assign legal    = (rom_code.len != 4'd0);
  assign last_bit = (state_q == SHIFT) && (cnt_q == 4'd1);
  // rst gates ready so nothing is advertised while the link is held in reset.
  assign sym_ready = !rst && ((state_q == IDLE) || last_bit);
  assign accept    = sym_valid && sym_ready;

  assign busy      = (state_q == SHIFT);
  assign bit_valid = busy;
  assign bit_out   = busy && sreg_q[8];
  assign bit_first = busy && first_q;
  assign sym_count = sym_count_q;

  // State, shift register and symbol counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      sym_count_q <= sym_count_d;
    end
  end

  // Next state: a legal accept (from IDLE or on the last bit) reloads directly,
  // otherwise keep shifting until the counter runs out.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    sym_count_d = sym_count_q;
    if (accept && legal) begin
      state_d     = SHIFT;
      sreg_d      = rom_code.code;
      cnt_d       = rom_code.len;
      first_d     = 1'b1;
      sym_count_d = sym_count_q + CNT_W'(1);
    end else if (state_q == SHIFT) begin
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end else begin
        sreg_d = {sreg_q[7:0], 1'b0};
        cnt_d  = cnt_q - 4'd1;
      end
    end
  end

`ifdef HUFF_ENC_ERR_CHECK_EN
  logic err_q;

  // One-cycle error pulse after an illegal symbol is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !legal;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
